// File: rtl/rv32i_regfile_pkg.sv
// Shared definitions for the rv32i parametrised register file:
// clear-sequencer state encoding, architectural address width and a width helper.
package rv32i_regfile_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  // Number of bits needed to index 'value' entries (value >= 2).
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        width = i + 1;
      end else begin
        width = width;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/rv32i_regfile_clr.sv
// Post-reset clear sequencer: walks registers 1..NREGS-1 writing zero,
// then parks in READY until the next reset.
module rv32i_regfile_clr
  import rv32i_regfile_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  output logic                      clr_we,
  output logic [clog2(NREGS)-1:0]   clr_addr,
  output logic                      ready
);

  localparam int IDX_W = clog2(NREGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  clr_state_e       state_r;
  clr_state_e       state_s;
  logic [IDX_W-1:0] cnt_r;
  logic [IDX_W-1:0] cnt_s;

  // state and clear-counter registers; x0 is hardwired so the walk starts at 1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= CLEAR;
      cnt_r   <= IDX_W'(1'b1);
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // next-state and clear-write generation
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    clr_we   = 1'b0;
    clr_addr = cnt_r;
    case (state_r)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_s  = cnt_r + IDX_W'(1'b1);
        if (cnt_r == LAST_IDX) begin
          state_s = READY;
        end else begin
          state_s = CLEAR;
        end
      end
      READY: begin
        state_s = READY;
      end
      default: begin
        state_s = CLEAR;
      end
    endcase
  end

  assign ready = (state_r == READY);

endmodule

// File: rtl/rv32i_regfile_mp.sv
// Parametrised rv32i integer register file: NRD latched-address read ports,
// optional same-cycle write-through, zeroed by a clear sequencer after reset.
module rv32i_regfile_mp
  import rv32i_regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_ce_stage1,
  input  logic                       i_ce_stage5,
  input  logic [REG_ADDR_W*NRD-1:0]  i_rs_addr,
  input  logic [REG_ADDR_W-1:0]      i_rd_addr,
  input  logic [XLEN-1:0]            i_rd,
  input  logic                       i_wr,
  output logic [XLEN*NRD-1:0]        o_rs,
  output logic                       o_ready
);

  localparam int IDX_W = clog2(NREGS);
  localparam logic [REG_ADDR_W:0] NREGS_C = (REG_ADDR_W + 1)'(NREGS);

  logic                  clr_we_s;
  logic [IDX_W-1:0]      clr_addr_s;
  logic                  ready_s;
  logic                  ce5_r;
  logic [REG_ADDR_W-1:0] rs_addr_r [NRD];
  logic [XLEN-1:0]       regs_r [1:NREGS-1];
  logic                  wb_commit_s;
  logic                  we_s;
  logic [IDX_W-1:0]      waddr_s;
  logic [XLEN-1:0]       wdata_s;
  logic [XLEN-1:0]       rs_s [NRD];

  rv32i_regfile_clr #(
    .NREGS (NREGS)
  ) u_clr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .clr_we   (clr_we_s),
    .clr_addr (clr_addr_s),
    .ready    (ready_s)
  );

  assign o_ready = ready_s;

  // Writeback lands only with the delayed stage-5 enable and a legal non-zero target.
  assign wb_commit_s = ready_s & ce5_r & i_wr
                     & (i_rd_addr != {REG_ADDR_W{1'b0}})
                     & ({1'b0, i_rd_addr} < NREGS_C);

  // stage-5 enable delay and read-address capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ce5_r <= 1'b0;
      for (int k = 0; k < NRD; k++) begin
        rs_addr_r[k] <= {REG_ADDR_W{1'b0}};
      end
    end else begin
      ce5_r <= i_ce_stage5;
      if (i_ce_stage1) begin
        for (int k = 0; k < NRD; k++) begin
          rs_addr_r[k] <= i_rs_addr[REG_ADDR_W*k +: REG_ADDR_W];
        end
      end
    end
  end

  // clear sequencer and writeback never overlap, clear simply takes priority
  always_comb begin
    we_s    = 1'b0;
    waddr_s = {IDX_W{1'b0}};
    wdata_s = {XLEN{1'b0}};
    if (clr_we_s) begin
      we_s    = 1'b1;
      waddr_s = clr_addr_s;
      wdata_s = {XLEN{1'b0}};
    end else begin
      we_s    = wb_commit_s;
      waddr_s = i_rd_addr[IDX_W-1:0];
      wdata_s = i_rd;
    end
  end

  // register array storage (no reset; the clear sequence initialises it)
  always_ff @(posedge i_clk) begin
    if (we_s) begin
      regs_r[waddr_s] <= wdata_s;
    end
  end

  // read ports with hardwired x0, out-of-range zero and optional write-through
  always_comb begin
    o_rs = {(XLEN*NRD){1'b0}};
    for (int k = 0; k < NRD; k++) begin
      rs_s[k] = {XLEN{1'b0}};
      if (!ready_s) begin
        rs_s[k] = {XLEN{1'b0}};
      end else if ((rs_addr_r[k] == {REG_ADDR_W{1'b0}}) || ({1'b0, rs_addr_r[k]} >= NREGS_C)) begin
        rs_s[k] = {XLEN{1'b0}};
      end else if ((BYPASS != 32'sd0) && wb_commit_s && (i_rd_addr == rs_addr_r[k])) begin
        rs_s[k] = i_rd;
      end else begin
        rs_s[k] = regs_r[rs_addr_r[k][IDX_W-1:0]];
      end
      o_rs[XLEN*k +: XLEN] = rs_s[k];
    end
  end

endmodule

// File: doc/rv32i_regfile_mp.md
Name: rv32i_regfile_mp

Overview:
Parametrised integer register file for the rv32i core. It replaces the fixed 32x32, 2-read-port base register file.
- Supports configurable data width and register count (32 for RV32I, 16 for RV32E).
- Supports N synchronous-address read ports and an optional same-cycle write-through bypass.
- After reset, a clear sequencer zeroes every register before the file reports ready.
- Sits between stage-1 decode (read address capture) and stage-5 writeback.

Parameters:
XLEN, 32, data width of each register in bits
NREGS, 32, number of architectural registers; legal values 16 or 32; register 0 hardwired to zero
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = a committing write is forwarded to matching read ports in the same cycle; 0 = no forwarding

Ports:
i_clk  input  1  clock
i_rst_n  input  1  reset; asynchronous assert, active-low
i_ce_stage1  input  1  stage-1 clock enable; read addresses are captured only when high
i_ce_stage5  input  1  stage-5 clock enable; registered internally, and the delayed copy gates writes
i_rs_addr  input  5*NRD  read addresses, flattened; port k is bits [5k+4:5k]
i_rd_addr  input  5  destination register address
i_rd  input  XLEN  writeback data
i_wr  input  1  write request
o_rs  output  XLEN*NRD  read data, flattened; port k is bits [XLEN*k+XLEN-1:XLEN*k]
o_ready  output  1  high once the post-reset clear sequence has completed

Behaviour:
- Reset: one clock; asynchronous, active-low reset (i_rst_n).
- Values while i_rst_n=0:
  - o_ready=0
  - all latched read addresses = 0, so all o_rs = 0
  - ce_stage5_q = 0
  - clear counter = 1
  - FSM = CLEAR
- Register array contents are not reset directly; the CLEAR state overwrites them.
- FSM states: CLEAR, READY.
  - CLEAR: each clock writes 0 to reg[cnt], then cnt++.
  - On the cycle reg[NREGS-1] is written, go to READY.
  - CLEAR lasts exactly NREGS-1 cycles after reset deasserts.
  - o_ready rises on the first READY cycle.
  - Reset asserted mid-CLEAR or in READY returns to CLEAR with cnt=1.
- Write commit: at a posedge when all of the following hold:
  - FSM=READY
  - ce_stage5_q=1 (i_ce_stage5 from the previous cycle)
  - i_wr=1
  - i_rd_addr!=0
  - i_rd_addr<NREGS
  Then reg[i_rd_addr] <= i_rd. Writes that fail any condition are silently dropped, including writes during CLEAR.
- Read address capture: when i_ce_stage1=1, each latched address is loaded from its i_rs_addr slice. When i_ce_stage1=0, latched addresses hold.
- Read data for port k (combinational from the latched address a_k):
  - a_k==0 or a_k>=NREGS -> 0
  - else if BYPASS=1 and a write commit condition is true this cycle with i_rd_addr==a_k -> i_rd
  - else reg[a_k]
  - While FSM=CLEAR, all o_rs = 0 regardless of address.
- Latency:
  - Read data is valid the cycle after address capture.
  - With BYPASS=1, a write is visible in the same cycle it commits. With BYPASS=0, it is visible the cycle after.
- Simultaneous events: multiple read ports with the same address all return the same value, and all see the bypass. A write and an address capture on the same edge are independent.
- NREGS=16: addresses 16..31 read as 0 and writes to them are ignored (RV32E illegal-register handling happens upstream).

Decomposition:
- Shared package rv32i_regfile_pkg:
  - FSM state encoding (CLEAR=1'b0, READY=1'b1)
  - localparam REG_ADDR_W=5
  - function clog2 for the clear counter width
- Sub-module rv32i_regfile_clr:
  - contains the clear FSM and counter
  - outputs clr_we, clr_addr, ready
- The top level muxes the clear write against the writeback write.

Test Plan:
- Reset then release, NREGS=32 -> o_ready low for exactly 31 cycles, then high; reading all 32 addresses returns 0.
- Preload via clear, then i_ce_stage5=1 for one cycle and the next cycle i_wr=1, rd=5, data=0xDEADBEEF; capture rs1=5 one cycle later -> o_rs[0]=0xDEADBEEF. Repeat with ce_stage5_q=0 -> value unchanged.
- Write to x0 with data 0x12345678 -> reading x0 returns 0. NREGS=16: write x20 -> reading x20 returns 0 and x4 is unaffected.
- BYPASS=1: latched rs2=7 and a commit to x7 with data 0xA5A5A5A5 in the same cycle -> o_rs[1]=0xA5A5A5A5 that cycle. With BYPASS=0, the old value is shown that cycle and 0xA5A5A5A5 the next.
- i_ce_stage1=0 while i_rs_addr changes 3->9 -> output keeps showing x3 until i_ce_stage1=1.
- Assert i_rst_n low mid-CLEAR (cycle 10) and during READY after writes -> o_ready drops immediately and the full 31-cycle clear repeats; a write attempted during CLEAR is dropped.
